// File: rtl/mips_mc_controller_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, functs,
// ALU/mux select codes and FSM state codes.
package mips_mc_controller_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_RD2   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_IEXEC  = 4'd9;
    localparam logic [3:0] S_IWB    = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_IMM   = 2'b11
    } aluOp_t;

    // andi/ori take a zero-extended immediate; everything else sign-extends.
    function automatic logic isImmLogic(input logic [5:0] op);
        return (op == OP_ANDI) || (op == OP_ORI);
    endfunction

endpackage

// File: rtl/mips_mc_controller_aludec.sv
// ALU sub-decoder: maps ALUOp plus Funct/Op to the 3-bit ALU control code,
// and flags whether Funct is one of the supported R-type operations.
module mips_aludec
    import mips_mc_controller_pkg::*;
(
    input  aluOp_t      ALUOp,
    input  logic [5:0]  Funct,
    input  logic [5:0]  Op,
    output logic [2:0]  ALUCtl,
    output logic        FunctValid
);

    logic [2:0] functCtl;
    logic [2:0] immCtl;

    always_comb begin
        functCtl   = ALU_ADD;
        FunctValid = 1'b1;
        case (Funct)
            FUNCT_ADD: functCtl = ALU_ADD;
            FUNCT_SUB: functCtl = ALU_SUB;
            FUNCT_AND: functCtl = ALU_AND;
            FUNCT_OR:  functCtl = ALU_OR;
            FUNCT_SLT: functCtl = ALU_SLT;
            default:   FunctValid = 1'b0;
        endcase
    end

    always_comb begin
        immCtl = ALU_ADD;
        case (Op)
            OP_ANDI: immCtl = ALU_AND;
            OP_ORI:  immCtl = ALU_OR;
            OP_SLTI: immCtl = ALU_SLT;
            default: immCtl = ALU_ADD;
        endcase
    end

    always_comb begin
        ALUCtl = ALU_ADD;
        case (ALUOp)
            ALUOP_ADD:   ALUCtl = ALU_ADD;
            ALUOP_SUB:   ALUCtl = ALU_SUB;
            ALUOP_FUNCT: ALUCtl = functCtl;
            ALUOP_IMM:   ALUCtl = immCtl;
            default:     ALUCtl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control unit: Moore FSM (one state per clock) driving all
// datapath selects/enables, with write enables gated off while Reset is low.
module mips_mc_controller
    import mips_mc_controller_pkg::*;
#(
    parameter int STATE_W = 4
)
(
    input  logic               CLK,
    input  logic               Reset,
    input  logic [5:0]         Op,
    input  logic [5:0]         Funct,
    input  logic               Zero,
    output logic               IorD,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegDst,
    output logic               MemToReg,
    output logic               ALUSrcA,
    output logic               RegWrite,
    output logic               PCEn,
    output logic               ExtOp,
    output logic [2:0]         ALUCtl,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         PCSrc,
    output logic [STATE_W-1:0] State
);

    logic [STATE_W-1:0] stateReg;
    logic [STATE_W-1:0] stateNext;
    aluOp_t             aluOp;
    logic               functValid;
    logic               memWriteRaw;
    logic               irWriteRaw;
    logic               regWriteRaw;
    logic               pcEnRaw;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            stateReg <= S_FETCH;
        end else begin
            stateReg <= stateNext;
        end
    end

    always_comb begin
        stateNext = S_FETCH;
        case (stateReg)
            S_FETCH:  stateNext = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW:                         stateNext = S_MEMADR;
                    OP_RTYPE:                             stateNext = S_EXEC;
                    OP_BEQ, OP_BNE:                       stateNext = S_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:    stateNext = S_IEXEC;
                    OP_J:                                 stateNext = S_JUMP;
                    default:                              stateNext = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (Op == OP_LW) begin
                    stateNext = S_MEMRD;
                end else if (Op == OP_SW) begin
                    stateNext = S_MEMWR;
                end else begin
                    stateNext = S_FETCH;
                end
            end
            S_MEMRD:  stateNext = S_MEMWB;
            S_EXEC:   stateNext = S_ALUWB;
            S_IEXEC:  stateNext = S_IWB;
            default:  stateNext = S_FETCH;
        endcase
    end

    always_comb begin
        IorD        = 1'b0;
        memWriteRaw = 1'b0;
        irWriteRaw  = 1'b0;
        RegDst      = 1'b0;
        MemToReg    = 1'b0;
        ALUSrcA     = 1'b0;
        regWriteRaw = 1'b0;
        pcEnRaw     = 1'b0;
        ExtOp       = 1'b1;
        aluOp       = ALUOP_ADD;
        ALUSrcB     = SRCB_RD2;
        PCSrc       = PCSRC_ALU;
        case (stateReg)
            S_FETCH: begin
                irWriteRaw = 1'b1;
                ALUSrcB    = SRCB_FOUR;
                pcEnRaw    = 1'b1;
            end
            S_DECODE: begin
                ALUSrcB = SRCB_IMMSH;
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMRD: begin
                IorD = 1'b1;
            end
            S_MEMWB: begin
                MemToReg    = 1'b1;
                regWriteRaw = 1'b1;
            end
            S_MEMWR: begin
                IorD        = 1'b1;
                memWriteRaw = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                aluOp   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                RegDst      = 1'b1;
                // Unsupported functs complete as no-ops rather than writing garbage.
                regWriteRaw = functValid;
            end
            S_BRANCH: begin
                ALUSrcA = 1'b1;
                aluOp   = ALUOP_SUB;
                PCSrc   = PCSRC_ALUOUT;
                pcEnRaw = ((Op == OP_BEQ) && Zero) || ((Op == OP_BNE) && !Zero);
            end
            S_IEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                ExtOp   = !isImmLogic(Op);
                aluOp   = ALUOP_IMM;
            end
            S_IWB: begin
                regWriteRaw = 1'b1;
            end
            S_JUMP: begin
                PCSrc   = PCSRC_JUMP;
                pcEnRaw = 1'b1;
            end
            default: ;
        endcase
    end

    // Architectural side effects are blocked the instant Reset falls.
    assign MemWrite = memWriteRaw & Reset;
    assign IRWrite  = irWriteRaw & Reset;
    assign RegWrite = regWriteRaw & Reset;
    assign PCEn     = pcEnRaw & Reset;
    assign State    = stateReg;

    mips_aludec u_aludec (
        .ALUOp      (aluOp),
        .Funct      (Funct),
        .Op         (Op),
        .ALUCtl     (ALUCtl),
        .FunctValid (functValid)
    );

endmodule

// File: tb/tb_mips_mc_controller.sv
// Bench for mips_mc_controller: per-instruction expected control-vector
// sequences built from the instruction's semantics, compared every cycle.
module tb_mips_mc_controller;
    import mips_mc_controller_pkg::*;

    typedef struct packed {
        logic [3:0] state;
        logic       iorD;
        logic       memWrite;
        logic       irWrite;
        logic       regDst;
        logic       memToReg;
        logic       aluSrcA;
        logic       regWrite;
        logic       pcEn;
        logic       extOp;
        logic [2:0] aluCtl;
        logic [1:0] aluSrcB;
        logic [1:0] pcSrc;
    } ctl_t;

    logic       CLK   = 1'b0;
    logic       Reset = 1'b1;
    logic [5:0] Op    = 6'b0;
    logic [5:0] Funct = 6'b0;
    logic       Zero  = 1'b0;
    logic       IorD, MemWrite, IRWrite, RegDst, MemToReg, ALUSrcA, RegWrite, PCEn, ExtOp;
    logic [2:0] ALUCtl;
    logic [1:0] ALUSrcB, PCSrc;
    logic [3:0] State;

    int checks = 0;
    int errors = 0;
    ctl_t obs;

    always #5 CLK = ~CLK;

    mips_mc_controller #(.STATE_W(4)) dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .Op       (Op),
        .Funct    (Funct),
        .Zero     (Zero),
        .IorD     (IorD),
        .MemWrite (MemWrite),
        .IRWrite  (IRWrite),
        .RegDst   (RegDst),
        .MemToReg (MemToReg),
        .ALUSrcA  (ALUSrcA),
        .RegWrite (RegWrite),
        .PCEn     (PCEn),
        .ExtOp    (ExtOp),
        .ALUCtl   (ALUCtl),
        .ALUSrcB  (ALUSrcB),
        .PCSrc    (PCSrc),
        .State    (State)
    );

    assign obs = {State, IorD, MemWrite, IRWrite, RegDst, MemToReg, ALUSrcA,
                  RegWrite, PCEn, ExtOp, ALUCtl, ALUSrcB, PCSrc};

    function automatic ctl_t base(input logic [3:0] st);
        ctl_t c = '0;
        c.state  = st;
        c.extOp  = 1'b1;
        c.aluCtl = 3'b010;
        return c;
    endfunction

    function automatic ctl_t fetchVec();
        ctl_t c = base(S_FETCH);
        c.irWrite = 1'b1;
        c.aluSrcB = 2'b01;
        c.pcEn    = 1'b1;
        return c;
    endfunction

    function automatic ctl_t resetVec();
        ctl_t c = fetchVec();
        c.irWrite = 1'b0;
        c.pcEn    = 1'b0;
        return c;
    endfunction

    task automatic check(input ctl_t exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Entered at a negedge with the FSM in FETCH; drives one instruction and
    // checks its whole cycle sequence (optionally stopping early at stopAt).
    task automatic runInstr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                            input string tag, input int stopAt);
        ctl_t q[$];
        ctl_t v;
        logic valid;
        logic [2:0] rCtl;
        Op = op; Funct = fn; Zero = z;
        q.push_back(fetchVec());
        v = base(S_DECODE); v.aluSrcB = 2'b11; q.push_back(v);
        case (op)
            OP_LW, OP_SW: begin
                v = base(S_MEMADR); v.aluSrcA = 1'b1; v.aluSrcB = 2'b10; q.push_back(v);
                if (op == OP_LW) begin
                    v = base(S_MEMRD); v.iorD = 1'b1; q.push_back(v);
                    v = base(S_MEMWB); v.memToReg = 1'b1; v.regWrite = 1'b1; q.push_back(v);
                end else begin
                    v = base(S_MEMWR); v.iorD = 1'b1; v.memWrite = 1'b1; q.push_back(v);
                end
            end
            OP_RTYPE: begin
                valid = 1'b1;
                case (fn)
                    6'b100000: rCtl = 3'b010;
                    6'b100010: rCtl = 3'b110;
                    6'b100100: rCtl = 3'b000;
                    6'b100101: rCtl = 3'b001;
                    6'b101010: rCtl = 3'b111;
                    default: begin rCtl = 3'b010; valid = 1'b0; end
                endcase
                v = base(S_EXEC); v.aluSrcA = 1'b1; v.aluCtl = rCtl; q.push_back(v);
                v = base(S_ALUWB); v.regDst = 1'b1; v.regWrite = valid; q.push_back(v);
            end
            OP_BEQ, OP_BNE: begin
                v = base(S_BRANCH); v.aluSrcA = 1'b1; v.aluCtl = 3'b110; v.pcSrc = 2'b01;
                v.pcEn = (op == OP_BEQ) ? z : !z;
                q.push_back(v);
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
                v = base(S_IEXEC); v.aluSrcA = 1'b1; v.aluSrcB = 2'b10;
                v.extOp  = !(op == OP_ANDI || op == OP_ORI);
                v.aluCtl = (op == OP_ANDI) ? 3'b000 : (op == OP_ORI) ? 3'b001 :
                           (op == OP_SLTI) ? 3'b111 : 3'b010;
                q.push_back(v);
                v = base(S_IWB); v.regWrite = 1'b1; q.push_back(v);
            end
            OP_J: begin
                v = base(S_JUMP); v.pcSrc = 2'b10; v.pcEn = 1'b1; q.push_back(v);
            end
            default: ;
        endcase
        foreach (q[i]) begin
            #1;
            check(q[i], $sformatf("%s_c%0d", tag, i));
            if (i == stopAt) return;
            @(negedge CLK);
        end
        $display("instr %s op=%b funct=%b zero=%b cycles=%0d", tag, op, fn, z, q.size());
    endtask

    logic [5:0] opList[11] = '{OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BNE, OP_ADDI,
                               OP_ANDI, OP_ORI, OP_SLTI, OP_J, 6'b111111};
    logic [5:0] fnList[5]  = '{FUNCT_ADD, FUNCT_SUB, FUNCT_AND, FUNCT_OR, FUNCT_SLT};

    initial begin
        logic [5:0] rop, rfn;
        #2 Reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK); #1;
            check(resetVec(), $sformatf("reset_hold%0d", i));
        end
        @(negedge CLK);
        Reset = 1'b1;

        // Abort a lw in MEMRD with an asynchronous reset.
        runInstr(OP_LW, 6'b0, 1'b0, "lw_abort", 3);
        Reset = 1'b0;
        #1;
        check(resetVec(), "reset_async");
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK); #1;
            check(resetVec(), $sformatf("reset_mid%0d", i));
        end
        @(negedge CLK);
        Reset = 1'b1;

        runInstr(OP_LW,    6'b0,      1'b0, "lw",       -1);
        runInstr(OP_SW,    6'b0,      1'b0, "sw",       -1);
        runInstr(OP_RTYPE, FUNCT_ADD, 1'b0, "r_add",    -1);
        runInstr(OP_RTYPE, 6'b111111, 1'b0, "r_bad",    -1);
        runInstr(OP_BEQ,   6'b0,      1'b1, "beq_z1",   -1);
        runInstr(OP_BEQ,   6'b0,      1'b0, "beq_z0",   -1);
        runInstr(OP_BNE,   6'b0,      1'b1, "bne_z1",   -1);
        runInstr(OP_BNE,   6'b0,      1'b0, "bne_z0",   -1);
        runInstr(OP_ORI,   6'b0,      1'b0, "ori",      -1);
        runInstr(OP_SLTI,  6'b0,      1'b0, "slti",     -1);
        runInstr(OP_J,     6'b0,      1'b0, "j",        -1);
        runInstr(6'b111111, 6'b0,     1'b0, "nop",      -1);

        for (int n = 0; n < 80; n++) begin
            int k;
            k = $urandom_range(0, 11);
            rop = (k == 11) ? 6'($urandom_range(0, 63)) : opList[k];
            rfn = ($urandom_range(0, 1) == 0) ? fnList[$urandom_range(0, 4)]
                                              : 6'($urandom_range(0, 63));
            runInstr(rop, rfn, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", n), -1);
        end

        #1;
        check(fetchVec(), "final_fetch");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
